sc_bitstream_decoder: RTL and testbench

Downstream consumer of stochastic bitstreams (delay, arithmetic and buffer stages). Counts ones on a serial bit input over a fixed window of N = 2^WINDOW_LOG qualified samples. Emits the count as a fixed-point estimate, with a one-cycle valid pulse.
Sits at the exit of stochastic datapaths, returning results to the binary domain for readout and checking.

---
 rtl/sc_bitstream_decoder.sv | 113 +++++++++++
 tb/tb_sc_bitstream_decoder.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_bitstream_decoder.sv
// rtl/sc_bitstream_decoder.sv - stochastic bitstream window decoder (optional bipolar output: SC_DECODER_BIPOLAR_EN)
module sc_bitstream_decoder #(
    parameter int WINDOW_LOG = 8,
    parameter bit CONTINUOUS = 1'b1
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  start,
    input  logic                  en,
    input  logic                  x,
    input  logic                  clear,
    output logic [WINDOW_LOG+1:0] y,
    output logic                  valid,
    output logic                  busy
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WINDOW_LOG:0]   r_count;
    logic [WINDOW_LOG:0]   w_count_nxt;
    logic [WINDOW_LOG-1:0] r_index;
    logic [WINDOW_LOG-1:0] w_index_nxt;
    logic                  r_valid;
    logic                  w_valid_nxt;
    logic [WINDOW_LOG+1:0] r_y;
    logic                  w_y_load;
    logic                  w_last;
    logic [WINDOW_LOG:0]   w_count_inc;
    logic [WINDOW_LOG+1:0] w_y_result;

    // The window holds N = 2^WINDOW_LOG samples, so the last index is all ones.
    assign w_last      = &r_index;
    assign w_count_inc = r_count + (WINDOW_LOG+1)'(x);

`ifdef SC_DECODER_BIPOLAR_EN
    localparam logic [WINDOW_LOG+1:0] N_EXT = (WINDOW_LOG+2)'(1) << WINDOW_LOG;
    // Map count 0..N onto -N..+N: 2*count - N in two's complement.
    assign w_y_result = {w_count_inc, 1'b0} - N_EXT;
`else
    // Plain ones count, zero-extended.
    assign w_y_result = {1'b0, w_count_inc};
`endif

    // Next-state, counter and result-load decisions; clear overrides everything.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_index_nxt = r_index;
        w_valid_nxt = 1'b0;
        w_y_load    = 1'b0;
        if (clear) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
            w_index_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_count_nxt = '0;
                    w_index_nxt = '0;
                    if (start) begin
                        w_state_nxt = S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (en) begin
                        if (w_last) begin
                            w_y_load    = 1'b1;
                            w_valid_nxt = 1'b1;
                            w_count_nxt = '0;
                            w_index_nxt = '0;
                            w_state_nxt = CONTINUOUS ? S_ACCUM : S_IDLE;
                        end else begin
                            w_count_nxt = w_count_inc;
                            w_index_nxt = r_index + WINDOW_LOG'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // State, accumulator, result and valid registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_index <= '0;
            r_valid <= 1'b0;
            r_y     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_index <= w_index_nxt;
            r_valid <= w_valid_nxt;
            if (w_y_load) begin
                r_y <= w_y_result;
            end
        end
    end

    assign y     = r_y;
    assign valid = r_valid;
    assign busy  = (r_state == S_ACCUM);

endmodule

// File: tb/tb_sc_bitstream_decoder.sv
// tb/tb_sc_bitstream_decoder.sv - directed self-checking bench for sc_bitstream_decoder
module tb_sc_bitstream_decoder;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       s4 = 1'b0, e4 = 1'b0, x4 = 1'b0, c4 = 1'b0;
    logic [5:0] y4;
    logic       v4, b4;
    logic       s2 = 1'b0, e2 = 1'b0, x2 = 1'b0, c2 = 1'b0;
    logic [3:0] y2;
    logic       v2, b2;

    int n_checks = 0;
    int n_errors = 0;

    sc_bitstream_decoder #(.WINDOW_LOG(4), .CONTINUOUS(1'b0)) u_dec4 (
        .CLK(CLK), .nRST(nRST), .start(s4), .en(e4), .x(x4), .clear(c4),
        .y(y4), .valid(v4), .busy(b4)
    );

    sc_bitstream_decoder #(.WINDOW_LOG(2), .CONTINUOUS(1'b1)) u_dec2 (
        .CLK(CLK), .nRST(nRST), .start(s2), .en(e2), .x(x2), .clear(c2),
        .y(y2), .valid(v2), .busy(b2)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [5:0] exp4(input int cnt);
`ifdef SC_DECODER_BIPOLAR_EN
        return 6'(2 * cnt - 16);
`else
        return 6'(cnt);
`endif
    endfunction

    function automatic logic [3:0] exp2(input int cnt);
`ifdef SC_DECODER_BIPOLAR_EN
        return 4'(2 * cnt - 4);
`else
        return 4'(cnt);
`endif
    endfunction

    initial begin
        logic       seen;
        logic [7:0] seq2;
        logic [18:0] en_pat;
        logic [18:0] x_pat;

        // Reset state
        tick();
        tick();
        check_eq("rst_y", 32'(y4), 32'd0);
        check_eq("rst_valid", 32'(v4), 32'd0);
        check_eq("rst_busy", 32'(b4), 32'd0);
        nRST = 1'b1;
        tick();
        check_eq("idle_busy", 32'(b4), 32'd0);

        // Full ones, single-shot window
        s4 = 1'b1; x4 = 1'b1;
        tick();
        s4 = 1'b0;
        check_eq("a_busy_start", 32'(b4), 32'd1);
        check_eq("a_count_after_start", 32'(u_dec4.r_count), 32'd0);
        e4 = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (v4) seen = 1'b1;
        end
        check_eq("a_no_early_valid", 32'(seen), 32'd0);
        tick();
        check_eq("a_valid", 32'(v4), 32'd1);
        check_eq("a_y", 32'(y4), 32'(exp4(16)));
        check_eq("a_busy_fall", 32'(b4), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (v4 || b4) seen = 1'b1;
        end
        check_eq("a_no_restart", 32'(seen), 32'd0);
        check_eq("a_y_hold", 32'(y4), 32'(exp4(16)));

        // Alternating bits, three stall cycles with x=1
        en_pat = 19'b1110111011110111111;
        x_pat  = '0;
        begin
            int k;
            k = 0;
            for (int i = 0; i < 19; i++) begin
                if (!en_pat[i]) x_pat[i] = 1'b1;
                else begin
                    x_pat[i] = (k % 2 == 0);
                    k++;
                end
            end
        end
        e4 = 1'b0;
        s4 = 1'b1;
        tick();
        s4 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 19; i++) begin
            e4 = en_pat[i];
            x4 = x_pat[i];
            tick();
            if (i < 18 && v4) seen = 1'b1;
            if (i == 15) check_eq("b_busy_mid", 32'(b4), 32'd1);
        end
        check_eq("b_no_early_valid", 32'(seen), 32'd0);
        check_eq("b_valid", 32'(v4), 32'd1);
        check_eq("b_y", 32'(y4), 32'(exp4(8)));
        e4 = 1'b0;
        tick();
        check_eq("b_valid_pulse", 32'(v4), 32'd0);

        // Continuous back-to-back windows of four
        seq2 = 8'b1000_0111;
        s2 = 1'b1;
        tick();
        s2 = 1'b0;
        e2 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            x2 = seq2[i];
            tick();
            check_eq($sformatf("c_busy_%0d", i), 32'(b2), 32'd1);
            if (i == 3) begin
                check_eq("c_valid_w0", 32'(v2), 32'd1);
                check_eq("c_y_w0", 32'(y2), 32'(exp2(3)));
            end else if (i == 7) begin
                check_eq("c_valid_w1", 32'(v2), 32'd1);
                check_eq("c_y_w1", 32'(y2), 32'(exp2(1)));
            end else begin
                check_eq($sformatf("c_novalid_%0d", i), 32'(v2), 32'd0);
            end
        end
        e2 = 1'b0;
        c2 = 1'b1;
        tick();
        c2 = 1'b0;
        check_eq("c_clear_busy", 32'(b2), 32'd0);

        // Async reset mid-window
        s4 = 1'b1;
        tick();
        s4 = 1'b0;
        e4 = 1'b1; x4 = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        #2;
        nRST = 1'b0;
        #1;
        check_eq("e_rst_y", 32'(y4), 32'd0);
        check_eq("e_rst_valid", 32'(v4), 32'd0);
        check_eq("e_rst_busy", 32'(b4), 32'd0);
        #3;
        nRST = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (v4 || b4) seen = 1'b1;
        end
        check_eq("e_needs_start", 32'(seen), 32'd0);

        // Three ones, then clear-with-start mid-window
        e4 = 1'b0;
        s4 = 1'b1;
        tick();
        s4 = 1'b0;
        e4 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            x4 = (i == 2 || i == 9 || i == 15);
            tick();
        end
        check_eq("d_valid3", 32'(v4), 32'd1);
        check_eq("d_y3", 32'(y4), 32'(exp4(3)));
        s4 = 1'b1;
        tick();
        s4 = 1'b0;
        x4 = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        c4 = 1'b1; s4 = 1'b1;
        tick();
        c4 = 1'b0; s4 = 1'b0;
        check_eq("d_clr_busy", 32'(b4), 32'd0);
        check_eq("d_clr_valid", 32'(v4), 32'd0);
        check_eq("d_clr_y", 32'(y4), 32'(exp4(3)));
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (v4 || b4) seen = 1'b1;
        end
        check_eq("d_no_partial", 32'(seen), 32'd0);
        s4 = 1'b1;
        x4 = 1'b0;
        tick();
        s4 = 1'b0;
        for (int i = 0; i < 16; i++) tick();
        check_eq("d_zero_valid", 32'(v4), 32'd1);
        check_eq("d_zero_y", 32'(y4), 32'(exp4(0)));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
